// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding master: turns a valid/ready read/write command stream into bus transactions.
// Optional watchdog enabled by defining AXIL_MST_TIMEOUT_EN.
module axil_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_AW_W,
    S_WR_B,
    S_RD_AR,
    S_RD_R,
    S_RSP
  } state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t                    r_state;
  state_t                    w_next;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_wstrb;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic [1:0]                r_resp;
  logic                      w_accept;
  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_ar_hs;
  logic                      w_timeout;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs   = M_AXI_WVALID && M_AXI_WREADY;
  assign w_ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;

`ifdef AXIL_MST_TIMEOUT_EN
  logic        w_busy;
  logic [15:0] r_cnt;

  assign w_busy    = (r_state == S_WR_AW_W) || (r_state == S_WR_B) ||
                     (r_state == S_RD_AR)   || (r_state == S_RD_R);
  assign w_timeout = w_busy && (r_cnt == TO_LIMIT);

  // Counter holds its value in RSP and is cleared once back in IDLE.
  always_ff @(posedge ACLK) begin
    if (ARESET || r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = ^TO_LIMIT;
  assign w_timeout   = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = req_write ? S_WR_AW_W : S_RD_AR;
      S_WR_AW_W: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WR_B;
      S_WR_B:    if (M_AXI_BVALID) w_next = S_RSP;
      S_RD_AR:   if (w_ar_hs) w_next = S_RD_R;
      S_RD_R:    if (M_AXI_RVALID) w_next = S_RSP;
      S_RSP:     if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_RSP;
  end

  // Command capture and response collection; write responses carry zero read data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= 2'b00;
    end else begin
      if (w_accept) begin
        r_addr    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        r_wdata   <= req_wdata;
        r_wstrb   <= req_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_rdata   <= '0;
        r_resp    <= 2'b00;
      end
      if (r_state == S_WR_AW_W) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if (r_state == S_WR_B && M_AXI_BVALID) begin
        r_resp <= M_AXI_BRESP;
      end
      if (r_state == S_RD_R && M_AXI_RVALID) begin
        r_rdata <= M_AXI_RDATA;
        r_resp  <= M_AXI_RRESP;
      end
      if (w_timeout) begin
        r_rdata <= DATA_WIDTH'(32'hDEAD_BEEF);
        r_resp  <= 2'b10;
      end
    end
  end

  // Channel handshakes are decoded from state so each valid drops right after its own handshake.
  assign req_ready     = (r_state == S_IDLE);
  assign rsp_valid     = (r_state == S_RSP);
  assign rsp_rdata     = r_rdata;
  assign rsp_resp      = r_resp;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = (r_state == S_WR_AW_W) && !r_aw_done;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = (r_state == S_WR_AW_W) && !r_w_done;
  assign M_AXI_BREADY  = (r_state == S_WR_B);
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = (r_state == S_RD_AR);
  assign M_AXI_RREADY  = (r_state == S_RD_R);

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
AXI4-Lite master engine driving the S00_AXI register slave of the test IP. It converts a simple valid/ready command stream (single 32-bit read or write) into AXI4-Lite transactions, with one transaction outstanding. The result is returned on a valid/ready response stream, replacing the VIP master in hardware builds.

Parameters:
ADDR_WIDTH, 32, byte address width of req_addr and M_AXI_AWADDR/ARADDR.
DATA_WIDTH, 32, data width; only 32 supported, WSTRB = DATA_WIDTH/8.
TIMEOUT_CYCLES, 256, watchdog limit used only with AXIL_MST_TIMEOUT_EN.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  synchronous reset, active-high.
req_valid  in  1  command valid.
req_ready  out  1  command accept; high only in IDLE.
req_write  in  1  1=write, 0=read.
req_addr  in  ADDR_WIDTH  byte address; bits [1:0] forced to 0 on the bus.
req_wdata  in  DATA_WIDTH  write data.
req_wstrb  in  DATA_WIDTH/8  write byte strobes.
rsp_valid  out  1  response valid, held until rsp_ready.
rsp_ready  in  1  response accept.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
rsp_resp  out  2  BRESP/RRESP captured from the slave.
M_AXI_AWADDR  out  ADDR_WIDTH  write address.
M_AXI_AWVALID  out  1  write address valid.
M_AXI_AWREADY  in  1  write address ready.
M_AXI_WDATA  out  DATA_WIDTH  write data.
M_AXI_WSTRB  out  DATA_WIDTH/8  write strobes.
M_AXI_WVALID  out  1  write data valid.
M_AXI_WREADY  in  1  write data ready.
M_AXI_BRESP  in  2  write response.
M_AXI_BVALID  in  1  write response valid.
M_AXI_BREADY  out  1  write response ready.
M_AXI_ARADDR  out  ADDR_WIDTH  read address.
M_AXI_ARVALID  out  1  read address valid.
M_AXI_ARREADY  in  1  read address ready.
M_AXI_RDATA  in  DATA_WIDTH  read data.
M_AXI_RRESP  in  2  read response.
M_AXI_RVALID  in  1  read data valid.
M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset: state IDLE; all VALID/READY outputs 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, AW/AR addr, WDATA, WSTRB 0. ARESET mid-transaction aborts immediately; all valids drop next edge; no response is issued. PROT is not generated; the integrator ties it to 3'b000.
- FSM states: IDLE -> (req_valid&req_ready) -> WR_AW_W if req_write, else RD_AR. Command fields are registered on accept.
- WR_AW_W: AWVALID and WVALID are asserted together the cycle after accept. Each drops the cycle after its own handshake; AW and W may complete in either order or in the same cycle. The state exits to WR_B when both are done.
- WR_B: BREADY=1; on BVALID capture BRESP -> RSP.
- RD_AR: ARVALID=1 until ARREADY -> RD_R. RD_R: RREADY=1; on RVALID capture RDATA/RRESP -> RSP.
- RSP: rsp_valid=1; on rsp_ready -> IDLE. req_ready returns the following cycle, so there is no back-to-back accept with rsp_ready.
- VALID is never withdrawn before READY, and address/data are stable while VALID is high.
- Minimum latency with slave READY tied high: write accept to rsp_valid = 3 cycles; read = 3 cycles.
- Non-OKAY responses are passed through unchanged and do not alter the FSM.

Optional Feature:
AXIL_MST_TIMEOUT_EN: defined -> a 16-bit counter runs in WR_AW_W/WR_B/RD_AR/RD_R and clears on entering IDLE. At TIMEOUT_CYCLES it drops all bus valids/readies and goes to RSP with rsp_resp=2'b10 and rsp_rdata=32'hDEAD_BEEF. Undefined -> no counter; waits indefinitely.

Test Plan:
- Write 0x00000001..0x00000004 to addrs 0x0,0x4,0x8,0xC, then read back -> each rsp_rdata matches, rsp_resp=2'b00.
- Slave holds AWREADY low 5 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 5 cycles with stable AWADDR, one BREADY pulse, single rsp.
- Slave returns RRESP=2'b10 on read of 0x8 -> rsp_resp=2'b10, rsp_rdata=RDATA.
- rsp_ready low 10 cycles -> rsp_valid and data held, req_ready=0, no AXI activity.
- ARESET asserted while in RD_R -> next cycle RREADY=0, state IDLE, rsp_valid=0.
- With AXIL_MST_TIMEOUT_EN, slave never raises BVALID -> after 256 cycles rsp_resp=2'b10 and rsp_rdata=32'hDEADBEEF.
